// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - pipeline-to-hazard-unit signal bundle
// master = pipeline datapath, slave = fwd_hazard_unit.
interface fwd_hazard_unit_if #(
  parameter int NUM_RS = 2,
  parameter int RA_W   = 5
);
  logic                     id_valid;
  logic [NUM_RS*RA_W-1:0]   id_rs;
  logic [NUM_RS-1:0]        id_rs_used;
  logic                     ex_valid;
  logic                     ex_wr;
  logic                     ex_is_load;
  logic [RA_W-1:0]          ex_rd;
  logic                     mem_wr;
  logic                     mem_is_load;
  logic                     mem_data_ready;
  logic [RA_W-1:0]          mem_rd;
  logic                     wb_wr;
  logic [RA_W-1:0]          wb_rd;
  logic                     flush;
  logic [NUM_RS*2-1:0]      ex_fwd_sel;
  logic                     ex_bubble;
  logic                     stall_id;
  logic [1:0]               fsm_state;

  modport master (
    output id_valid, id_rs, id_rs_used,
    output ex_valid, ex_wr, ex_is_load, ex_rd,
    output mem_wr, mem_is_load, mem_data_ready, mem_rd,
    output wb_wr, wb_rd, flush,
    input  ex_fwd_sel, ex_bubble, stall_id, fsm_state
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used,
    input  ex_valid, ex_wr, ex_is_load, ex_rd,
    input  mem_wr, mem_is_load, mem_data_ready, mem_rd,
    input  wb_wr, wb_rd, flush,
    output ex_fwd_sel, ex_bubble, stall_id, fsm_state
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding select and load/MEM stall control
// Optional FWD_PERF_CNT_EN adds saturating stall/forward performance counters.
module fwd_hazard_unit #(
  parameter int NUM_RS = 2,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef FWD_PERF_CNT_EN
  output logic [CNT_W-1:0]    perf_stall_cnt,
  output logic [CNT_W-1:0]    perf_fwd_cnt,
`endif
  fwd_hazard_unit_if.slave    hz
);

  localparam logic [1:0] ST_RUN       = 2'b00;
  localparam logic [1:0] ST_LU_BUBBLE = 2'b01;
  localparam logic [1:0] ST_MEM_WAIT  = 2'b10;

  // Selects name where the operand lives once the consumer reaches EX.
  localparam logic [1:0] SEL_ORG  = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_WB   = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  if (NUM_RS < 1 || NUM_RS > 4 || RA_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("fwd_hazard_unit: parameter out of range");
  end

  logic                 ex_prod;
  logic                 mem_prod;
  logic                 wb_prod;
  logic [NUM_RS-1:0]    ex_hit;
  logic [NUM_RS-1:0]    mem_hit;
  logic [NUM_RS-1:0]    wb_hit;
  logic [NUM_RS*2-1:0]  sel_next;
  logic                 ld_hazard;
  logic                 mem_hold;
  logic                 stall;
  logic                 advance;
  logic [NUM_RS*2-1:0]  sel_q;
  logic                 bubble_q;
  logic [1:0]           state_q;
  logic [1:0]           state_d;

  assign ex_prod  = hz.ex_valid & hz.ex_wr & (hz.ex_rd != '0);
  assign mem_prod = hz.mem_wr & (hz.mem_rd != '0);
  assign wb_prod  = hz.wb_wr & (hz.wb_rd != '0);

  for (genvar k = 0; k < NUM_RS; k++) begin : g_port
    logic [RA_W-1:0] rs;
    logic            live;

    assign rs         = hz.id_rs[k*RA_W +: RA_W];
    assign live       = hz.id_rs_used[k] & (rs != '0);
    assign ex_hit[k]  = live & ex_prod  & (rs == hz.ex_rd);
    assign mem_hit[k] = live & mem_prod & (rs == hz.mem_rd);
    assign wb_hit[k]  = live & wb_prod  & (rs == hz.wb_rd);

    // Youngest producer wins.
    assign sel_next[2*k +: 2] = ex_hit[k]  ? SEL_MEM  :
                                mem_hit[k] ? SEL_WB   :
                                wb_hit[k]  ? SEL_HOLD : SEL_ORG;
  end

  assign ld_hazard = hz.id_valid & hz.ex_is_load & (|ex_hit);
  assign mem_hold  = hz.mem_is_load & hz.mem_wr & ~hz.mem_data_ready;
  assign stall     = ~hz.flush & (ld_hazard | mem_hold);
  assign advance   = ~stall & ~hz.flush;

  always_comb begin
    state_d = ST_RUN;
    if (!hz.flush) begin
      case (state_q)
        ST_RUN: begin
          if (mem_hold)       state_d = ST_MEM_WAIT;
          else if (ld_hazard) state_d = ST_LU_BUBBLE;
          else                state_d = ST_RUN;
        end
        ST_LU_BUBBLE: state_d = mem_hold ? ST_MEM_WAIT : ST_RUN;
        ST_MEM_WAIT:  state_d = mem_hold ? ST_MEM_WAIT : ST_RUN;
        default:      state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= '0;
      bubble_q <= 1'b1;
      state_q  <= ST_RUN;
    end else begin
      state_q <= state_d;
      if (advance) begin
        sel_q    <= sel_next;
        bubble_q <= ~hz.id_valid;
      end else begin
        sel_q    <= '0;
        bubble_q <= 1'b1;
      end
    end
  end

  assign hz.ex_fwd_sel = sel_q;
  assign hz.ex_bubble  = bubble_q;
  assign hz.stall_id   = stall;
  assign hz.fsm_state  = state_q;

`ifdef FWD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      if (stall && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (advance && (|sel_next) && perf_fwd_cnt != '1)
        perf_fwd_cnt <= perf_fwd_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - scoreboard bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

  localparam int NUM_RS = 2;
  localparam int RA_W   = 5;
  localparam int CNT_W  = 4;

  localparam logic [1:0] RUN = 2'b00;
  localparam logic [1:0] LU  = 2'b01;
  localparam logic [1:0] MW  = 2'b10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fwd_hazard_unit_if #(.NUM_RS(NUM_RS), .RA_W(RA_W)) hz ();

`ifdef FWD_PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall_cnt;
  logic [CNT_W-1:0] perf_fwd_cnt;
`endif

  fwd_hazard_unit #(.NUM_RS(NUM_RS), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef FWD_PERF_CNT_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_fwd_cnt   (perf_fwd_cnt),
`endif
    .hz             (hz)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic       stall;
    logic [3:0] sel;
    logic       bubble;
    logic [1:0] st;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   vec = 0;

  task automatic chk(input string nm, input int id, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s v%0d: got %h want %h", nm, id, got, want);
    end
  endtask

  task automatic set_in(input logic idv, input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [1:0] used, input logic exv, input logic exw,
                        input logic exl, input logic [4:0] exrd, input logic mw,
                        input logic ml, input logic mr, input logic [4:0] mrd,
                        input logic ww, input logic [4:0] wrd, input logic fl);
    hz.id_valid       = idv;
    hz.id_rs          = {rs1, rs0};
    hz.id_rs_used     = used;
    hz.ex_valid       = exv;
    hz.ex_wr          = exw;
    hz.ex_is_load     = exl;
    hz.ex_rd          = exrd;
    hz.mem_wr         = mw;
    hz.mem_is_load    = ml;
    hz.mem_data_ready = mr;
    hz.mem_rd         = mrd;
    hz.wb_wr          = ww;
    hz.wb_rd          = wrd;
    hz.flush          = fl;
  endtask

  task automatic drive(input logic idv, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] used, input logic exv, input logic exw,
                       input logic exl, input logic [4:0] exrd, input logic mw,
                       input logic ml, input logic mr, input logic [4:0] mrd,
                       input logic ww, input logic [4:0] wrd, input logic fl,
                       input logic e_stall, input logic [3:0] e_sel,
                       input logic e_bub, input logic [1:0] e_st);
    exp_t e;
    @(negedge clk);
    set_in(idv, rs0, rs1, used, exv, exw, exl, exrd, mw, ml, mr, mrd, ww, wrd, fl);
    e.id = vec; e.stall = e_stall; e.sel = e_sel; e.bubble = e_bub; e.st = e_st;
    q.push_back(e);
    vec++;
  endtask

  // Inputs only change on negedge, so stall_id is still the value for the
  // cycle that just ended when registered outputs are sampled here.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall_id",   e.id, 16'(hz.stall_id),   16'(e.stall));
        chk("ex_fwd_sel", e.id, 16'(hz.ex_fwd_sel), 16'(e.sel));
        chk("ex_bubble",  e.id, 16'(hz.ex_bubble),  16'(e.bubble));
        chk("fsm_state",  e.id, 16'(hz.fsm_state),  16'(e.st));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel",    -1, 16'(hz.ex_fwd_sel), 16'h0);
    chk("rst_bubble", -1, 16'(hz.ex_bubble),  16'h1);
    chk("rst_state",  -1, 16'(hz.fsm_state),  16'(RUN));
    @(negedge clk);
    rst_n = 1'b1;

    //     idv rs0 rs1 used  exv exw exl exrd  mw ml mr mrd  ww wrd fl | stall sel      bub st
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4'b0000, 1, RUN);
    drive(1, 5, 7, 2'b11, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0,   0, 4'b0001, 0, RUN);
    drive(1, 5, 7, 2'b11, 1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0,   1, 4'b0000, 1, LU);
    drive(1, 5, 7, 2'b11, 0, 0, 0, 0, 1, 1, 1, 5, 0, 0, 0,   0, 4'b0010, 0, RUN);
    repeat (3)
      drive(1, 5, 7, 2'b11, 0, 0, 0, 0, 1, 1, 0, 3, 0, 0, 0, 1, 4'b0000, 1, MW);
    drive(1, 5, 7, 2'b11, 0, 0, 0, 0, 1, 1, 1, 3, 0, 0, 0,   0, 4'b0000, 0, RUN);
    drive(1, 9, 0, 2'b11, 1, 1, 0, 9, 1, 0, 0, 9, 1, 9, 0,   0, 4'b0001, 0, RUN);
    drive(1, 9, 4, 2'b11, 1, 1, 0, 4, 1, 0, 0, 9, 1, 9, 0,   0, 4'b0110, 0, RUN);
    drive(1, 9, 9, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0,   0, 4'b0011, 0, RUN);
    drive(1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 4'b0000, 0, RUN);
    drive(1, 0, 0, 2'b01, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4'b0000, 0, RUN);
    drive(1, 6, 0, 2'b01, 1, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0,   0, 4'b0000, 0, RUN);
    drive(0, 6, 0, 2'b01, 1, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0,   0, 4'b0001, 1, RUN);
    drive(1, 5, 7, 2'b11, 1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 1,   0, 4'b0000, 1, RUN);
    drive(1, 5, 7, 2'b11, 1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0,   1, 4'b0000, 1, LU);
    drive(1, 5, 7, 2'b11, 0, 0, 0, 0, 1, 1, 0, 5, 0, 0, 0,   1, 4'b0000, 1, MW);
    drive(1, 5, 7, 2'b11, 0, 0, 0, 0, 1, 1, 0, 5, 0, 0, 1,   0, 4'b0000, 1, RUN);
    drive(1, 5, 7, 2'b11, 0, 0, 0, 0, 1, 1, 0, 5, 0, 0, 0,   1, 4'b0000, 1, MW);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 3, 0, 0, 0,   1, 4'b0000, 1, MW);

    // Asynchronous reset in the middle of MEM_WAIT.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state",  -2, 16'(hz.fsm_state),  16'(RUN));
    chk("arst_sel",    -2, 16'(hz.ex_fwd_sel), 16'h0);
    chk("arst_bubble", -2, 16'(hz.ex_bubble),  16'h1);
    chk("arst_stall",  -2, 16'(hz.stall_id),   16'h1);
`ifdef FWD_PERF_CNT_EN
    chk("arst_pstall", -2, 16'(perf_stall_cnt), 16'h0);
`endif
    @(negedge clk);
    set_in(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_state", -3, 16'(hz.fsm_state), 16'(RUN));
    chk("rel_stall", -3, 16'(hz.stall_id),  16'h0);

    drive(1, 5, 7, 2'b11, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0,   0, 4'b0001, 0, RUN);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4'b0000, 1, RUN);

`ifdef FWD_PERF_CNT_EN
    @(posedge clk);
    #2;
    chk("pfwd_one", -4, 16'(perf_fwd_cnt),   16'h1);
    chk("pstall_0", -4, 16'(perf_stall_cnt), 16'h0);
    repeat (20)
      drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 3, 0, 0, 0, 1, 4'b0000, 1, MW);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4'b0000, 1, RUN);
    @(posedge clk);
    #2;
    chk("pstall_sat", -5, 16'(perf_stall_cnt), 16'hF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("pstall_clr", -5, 16'(perf_stall_cnt), 16'h0);
    chk("pfwd_clr",   -5, 16'(perf_fwd_cnt),   16'h0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", -9, 16'(q.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter NUM_RS, default 2, number of source-operand read ports checked per decoded instruction (1..4).
REQ-002 Parameter RA_W, default 5, register-address width.
REQ-003 Parameter CNT_W, default 16, width of each performance counter.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 id_valid  in  1  instruction in ID is valid.
REQ-007 id_rs  in  NUM_RS*RA_W  source register addresses, port k at bits [k*RA_W +: RA_W].
REQ-008 id_rs_used  in  NUM_RS  port k actually reads its register.
REQ-009 ex_valid, ex_wr, ex_is_load  in  1 each  EX-stage valid, register-write enable, load flag.
REQ-010 ex_rd  in  RA_W  EX-stage destination.
REQ-011 mem_wr, mem_is_load, mem_data_ready  in  1 each  MEM-stage write enable, load flag, load data available.
REQ-012 mem_rd  in  RA_W  MEM-stage destination.
REQ-013 wb_wr  in  1, wb_rd  in  RA_W  WB-stage write enable and destination.
REQ-014 flush  in  1  squash instruction in ID.
REQ-015 ex_fwd_sel  out  NUM_RS*2  registered per-port operand select for the instruction entering EX: 00 ORG, 01 MEM, 10 WB, 11 HOLD (value retired by WB one cycle earlier).
REQ-016 ex_bubble  out  1  registered; EX receives a bubble this cycle.
REQ-017 stall_id  out  1  combinational; hold PC/IF/ID this cycle.
REQ-018 fsm_state  out  2  current state: 00 RUN, 01 LU_BUBBLE, 10 MEM_WAIT.

Function
REQ-019 A producer stage is valid only if its write enable is 1 and its rd != 0; EX additionally requires ex_valid.
REQ-020 Per port k with id_rs_used[k]=1, select priority is EX match -> 01, else MEM match -> 10, else WB match -> 11, else 00; unused ports and rs=0 always give 00.
REQ-021 ld_hazard = id_valid & any used port matching a valid EX producer with ex_is_load=1.
REQ-022 mem_hold = mem_is_load & mem_wr & !mem_data_ready.
REQ-023 stall_id = !flush & (ld_hazard | mem_hold).
REQ-024 On each edge with stall_id=0 and flush=0, ex_fwd_sel loads the REQ-020 selects and ex_bubble loads !id_valid.
REQ-025 On each edge with stall_id=1 or flush=1, ex_fwd_sel loads all 00 and ex_bubble loads 1.
REQ-026 Forwarding-select latency is exactly one cycle from ID sampling to ex_fwd_sel.
REQ-027 RUN -> LU_BUBBLE when ld_hazard & !mem_hold & !flush; RUN -> MEM_WAIT when mem_hold & !flush.
REQ-028 LU_BUBBLE -> MEM_WAIT when mem_hold, else -> RUN; LU_BUBBLE lasts one cycle.
REQ-029 MEM_WAIT stays while mem_hold, -> RUN on the first cycle mem_data_ready=1.
REQ-030 flush forces the next state to RUN from any state and overrides every stall.
REQ-031 A load with rd=0 or ex_wr=0 never creates ld_hazard.
REQ-032 When both ports match different stages, each port resolves independently.

Reset
REQ-033 While rst_n=0: ex_fwd_sel=0, ex_bubble=1, state=RUN, counters=0, asynchronously.
REQ-034 Reset deassertion mid-stall resumes in RUN; stall_id then follows only current inputs.

Configuration
REQ-035 Macro FWD_PERF_CNT_EN defined: outputs perf_stall_cnt and perf_fwd_cnt (CNT_W each) are present; perf_stall_cnt increments each cycle stall_id=1, perf_fwd_cnt increments each unstalled, unflushed cycle with any non-00 select; both saturate at all-ones.
REQ-036 Macro undefined: neither port nor counter logic exists; all other behaviour is identical.

Verification
REQ-037 ex_rd=5, ex_wr=1, ex_valid=1, ex_is_load=0, id_rs={5,7}, used=11 -> next cycle port0 sel=01, port1 sel=00, stall_id=0.
REQ-038 Same with ex_is_load=1 -> stall_id=1 for one cycle, ex_bubble=1, state RUN->LU_BUBBLE->RUN, then port0 sel=10.
REQ-039 mem_is_load=1, mem_wr=1, mem_data_ready=0 for 3 cycles -> stall_id=1 three cycles, state MEM_WAIT, exit to RUN when ready=1.
REQ-040 ex_rd=mem_rd=wb_rd=9, all writing, id_rs[0]=9 -> sel=01; rs=0 with wb_rd=0 -> sel=00.
REQ-041 flush=1 during ld_hazard -> stall_id=0, ex_bubble=1, sel=00, state RUN.
REQ-042 rst_n low mid MEM_WAIT -> outputs reset immediately; with FWD_PERF_CNT_EN, perf_stall_cnt preloaded near all-ones saturates and clears to 0.
